// File: rtl/pipeline_pkg.sv
// Shared types and default parameters for the pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam int unsigned INIT_CYCLES_DEF = 3;
  localparam int unsigned MEM_TIMEOUT_DEF = 15;
  localparam int unsigned REG_W           = 5;
  localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: ID instruction needs a register a load in EX is still fetching.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rt,
  output logic       o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  // Register 0 is hardwired to zero, so a load into it never creates a dependency.
  assign w_rs_hit   = (i_ex_rt == i_id_rs);
  assign w_rt_hit   = i_id_uses_rt & (i_ex_rt == i_id_rt);
  assign o_load_use = i_ex_memread & (i_ex_rt != REG_W'(0)) & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: reset flush, memory-wait freeze with timeout,
// branch flush and load-use bubble, plus saturating performance counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        pc_sel,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);

  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 2);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [INIT_W-1:0]   r_init_cnt;
  logic [INIT_W-1:0]   w_init_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;
  logic                w_mem_stall;
  logic                w_load_use;
  logic                w_stall_inc;
  logic                w_flush_inc;

  hazard_detect u_hazard_detect (
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rt (id_uses_rt),
    .i_ex_memread (ex_memread),
    .i_ex_rt      (ex_rt),
    .o_load_use   (w_load_use)
  );

  assign w_mem_stall = mem_req & ~mem_ready;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Next state and control outputs; priority is memory stall, branch, load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_init_nxt  = r_init_cnt;
    w_wait_nxt  = '0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    pc_sel      = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mem_timeout = 1'b0;

    case (r_state)
      ST_INIT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
          w_init_nxt  = '0;
        end else begin
          w_init_nxt = r_init_cnt + INIT_W'(1);
        end
      end

      ST_RUN, ST_MEM_WAIT: begin
        if (w_mem_stall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_en    = 1'b0;
          w_stall_inc = 1'b1;
          // This stall cycle would make the consecutive count exceed the timeout.
          if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            w_state_nxt = ST_ERROR;
          end else begin
            w_state_nxt = ST_MEM_WAIT;
            w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          w_state_nxt = ST_RUN;
          if (ex_branch_taken) begin
            pc_sel      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_flush_inc = 1'b1;
          end else if (w_load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
          end
        end
      end

      ST_ERROR: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        mem_timeout = 1'b1;
      end

      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
